// File: rtl/mult_pkg.sv
// Shared widths, FSM state type and helpers for the multiplier and its BCD readout stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mult_pkg;

    localparam int DW    = 8;
    localparam int D2W   = 2 * DW;
    localparam int NDIG  = (3 * D2W + 9) / 10;
    localparam int CNT_W = $clog2(D2W + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } bcd_state_e;

    // True when every nibble of a packed BCD word is a legal decimal digit.
    function automatic logic bcd_digits_ok(input logic [4*NDIG-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a nibble that is 5 or more.
// Latency: combinational.
// Backpressure: none; pure function of its input.
module bcd_digit_adj (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    // The 4-bit sum deliberately discards any carry; digits never interact.
    assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/product_bcd_conv.sv
// Converts the multiplier's magnitude product to packed BCD, one bit per clock.
// Latency: o_valid in the 16th cycle after the accepting edge; period 18 cycles.
// Backpressure: i_valid is dropped (not queued) while o_busy is high, DONE included.
module product_bcd_conv
    import mult_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [D2W-1:0]    i_product,
    input  logic              i_neg,
    output logic              o_busy,
    output logic              o_valid,
    output logic              o_neg,
    output logic [4*NDIG-1:0] o_bcd
);

    localparam int BW = 4 * NDIG;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(D2W - 1);

    bcd_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [D2W-1:0]   shreg_q, shreg_d;
    logic [BW-1:0]    acc_q, acc_d;
    logic             sign_q, sign_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic             neg_q, neg_d;

    logic [BW-1:0]    acc_adj;
    logic [BW-1:0]    acc_sh;
    logic [D2W-1:0]   shreg_sh;

    for (genvar g = 0; g < NDIG; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (acc_q[4*g +: 4]),
            .digit_o (acc_adj[4*g +: 4])
        );
    end

    // One double-dabble step: corrected accumulator and shift register move left as one word.
    always_comb begin
        acc_sh   = {acc_adj[BW-2:0], shreg_q[D2W-1]};
        shreg_sh = {shreg_q[D2W-2:0], 1'b0};
    end

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            acc_q   <= '0;
            sign_q  <= 1'b0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            acc_q   <= acc_d;
            sign_q  <= sign_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
        end
    end

    // Next-state logic: accept only in IDLE, shift D2W times, one DONE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_valid) state_d = SHIFT;
            SHIFT:   if (cnt_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values; result registers change only on the final shift.
    always_comb begin
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        acc_d   = acc_q;
        sign_d  = sign_q;
        bcd_d   = bcd_q;
        neg_d   = neg_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    shreg_d = i_product;
                    acc_d   = '0;
                    // A zero magnitude never reports as negative.
                    sign_d  = i_neg & (i_product != '0);
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                acc_d   = acc_sh;
                shreg_d = shreg_sh;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    bcd_d = acc_sh;
                    neg_d = sign_q;
                end
            end
            default: begin
            end
        endcase
    end

    // Outputs decoded from state; result values come straight from their registers.
    always_comb begin
        o_busy  = (state_q != IDLE);
        o_valid = (state_q == DONE);
        o_bcd   = bcd_q;
        o_neg   = neg_q;
    end

    // The finished accumulator must hold only legal decimal digits.
    a_bcd_legal: assert property (@(posedge i_clk) disable iff (i_rst)
        (state_q == SHIFT && cnt_q == LAST) |-> bcd_digits_ok(acc_sh));

endmodule

// File: tb/tb_product_bcd_conv.sv
// Directed and randomised checks of the product-to-BCD converter.
// Latency: expects o_valid on the 17th edge counting the accepting edge as the first.
// Backpressure: exercises dropped requests while busy and reset aborts.
module tb_product_bcd_conv;
    import mult_pkg::*;

    logic              clk;
    logic              rst;
    logic              i_valid;
    logic [D2W-1:0]    i_product;
    logic              i_neg;
    logic              o_busy;
    logic              o_valid;
    logic              o_neg;
    logic [4*NDIG-1:0] o_bcd;

    int checks   = 0;
    int failures = 0;

    product_bcd_conv dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_valid   (i_valid),
        .i_product (i_product),
        .i_neg     (i_neg),
        .o_busy    (o_busy),
        .o_valid   (o_valid),
        .o_neg     (o_neg),
        .o_bcd     (o_bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4*NDIG-1:0] ref_bcd(input int unsigned v);
        string s;
        logic [4*NDIG-1:0] r;
        s = $sformatf("%05d", v);
        r = '0;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = 4'(s[NDIG-1-i] - 8'd48);
        end
        return r;
    endfunction

    // Issue one request and check latency, result, sign, pulse width and output stability.
    task automatic run_conv(input string tag, input logic [D2W-1:0] prod, input logic neg,
                            input logic [4*NDIG-1:0] exp_bcd, input logic exp_neg);
        int n;
        logic [4*NDIG-1:0] prev;
        logic moved;
        logic legal;
        prev      = o_bcd;
        moved     = 1'b0;
        i_product = prod;
        i_neg     = neg;
        i_valid   = 1'b1;
        tick();
        i_valid = 1'b0;
        n = 1;
        while (!o_valid && n < 40) begin
            if (o_bcd !== prev) moved = 1'b1;
            tick();
            n++;
        end
        legal = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (o_bcd[4*i +: 4] > 4'd9) legal = 1'b0;
        end
        check_eq({tag, "_latency"}, 32'(n), 32'd17);
        check_eq({tag, "_hold"},    32'(moved), 32'd0);
        check_eq({tag, "_bcd"},     32'(o_bcd), 32'(exp_bcd));
        check_eq({tag, "_neg"},     32'(o_neg), 32'(exp_neg));
        check_eq({tag, "_digits"},  32'(legal), 32'd1);
        tick();
        check_eq({tag, "_pulse"},   32'(o_valid), 32'd0);
        check_eq({tag, "_idle"},    32'(o_busy), 32'd0);
    endtask

    initial begin
        int n;
        logic seen_valid;
        logic busy_ok;
        int unsigned v;
        logic nb;

        rst       = 1'b1;
        i_valid   = 1'b0;
        i_product = '0;
        i_neg     = 1'b0;
        #1;
        check_eq("rst_busy",  32'(o_busy),  32'd0);
        check_eq("rst_valid", 32'(o_valid), 32'd0);
        check_eq("rst_neg",   32'(o_neg),   32'd0);
        check_eq("rst_bcd",   32'(o_bcd),   32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        run_conv("zero",     16'd0,     1'b0, 20'h00000, 1'b0);
        run_conv("max",      16'hFFFF,  1'b0, 20'h65535, 1'b0);
        run_conv("neg12345", 16'd12345, 1'b1, 20'h12345, 1'b1);
        run_conv("negzero",  16'd0,     1'b1, 20'h00000, 1'b0);
        run_conv("nines",    16'd9999,  1'b0, 20'h09999, 1'b0);

        // Requests arriving mid-conversion and in DONE must be dropped.
        i_product = 16'd999;
        i_neg     = 1'b0;
        i_valid   = 1'b1;
        tick();
        i_valid = 1'b0;
        n       = 1;
        busy_ok = 1'b1;
        while (!o_valid && n < 40) begin
            if (!o_busy) busy_ok = 1'b0;
            if (n == 2) begin
                i_product = 16'd7;
                i_valid   = 1'b1;
            end else begin
                i_valid = 1'b0;
            end
            tick();
            n++;
        end
        check_eq("drop_latency", 32'(n), 32'd17);
        check_eq("drop_busy",    32'(busy_ok), 32'd1);
        check_eq("drop_busy_done", 32'(o_busy), 32'd1);
        check_eq("drop_bcd",     32'(o_bcd), 32'h00999);
        i_product = 16'd7;
        i_valid   = 1'b1;
        tick();
        i_valid = 1'b0;
        check_eq("drop_idle", 32'(o_busy), 32'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (o_valid || o_busy) seen_valid = 1'b1;
            tick();
        end
        check_eq("drop_no_second", 32'(seen_valid), 32'd0);
        check_eq("drop_bcd_kept",  32'(o_bcd), 32'h00999);

        // Reset in the middle of a conversion aborts it without a result.
        i_product = 16'd4321;
        i_neg     = 1'b1;
        i_valid   = 1'b1;
        tick();
        i_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check_eq("abort_busy_pre", 32'(o_busy), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("abort_busy", 32'(o_busy), 32'd0);
        check_eq("abort_bcd",  32'(o_bcd),  32'd0);
        check_eq("abort_neg",  32'(o_neg),  32'd0);
        tick();
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (o_valid) seen_valid = 1'b1;
            tick();
        end
        check_eq("abort_no_valid", 32'(seen_valid), 32'd0);
        check_eq("abort_bcd_zero", 32'(o_bcd), 32'd0);
        run_conv("after_abort", 16'd4321, 1'b0, 20'h04321, 1'b0);

        // Random sweep against a decimal-string reference.
        for (int k = 0; k < 1500; k++) begin
            v  = $urandom_range(0, 65535);
            nb = 1'($urandom_range(0, 1));
            run_conv("rand", 16'(v), nb, ref_bcd(v), nb && (v != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
